// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and a clog2
// helper usable for counter sizing on both the rx and tx sides.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } uart_state_t;

   function automatic int uart_clog2(input int value);
      int r_bits;
      int r_rem;
      r_bits = 0;
      r_rem  = value - 1;
      while (r_rem > 0) begin
         r_bits++;
         r_rem = r_rem >> 1;
      end
      return r_bits;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start bit.
module uart_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b1;
         r_q    <= 1'b1;
      end else begin
         r_meta <= d;
         r_q    <= r_meta;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, framing-error strobe and break hold-off.
// Define UART_RX_PARITY_EN for 8E1 frames and the rx_parity_err output.
//
// state  | meaning
// IDLE   | line idle, waiting for a low synchronised sample
// START  | confirm start bit at its middle, else reject as glitch
// DATA   | sample 8 data bits at mid-bit, LSB first
// PARITY | sample even-parity bit (parity build only)
// STOP   | sample stop bit; high -> byte out, low -> framing error
// BREAK  | line held low after a bad stop bit; wait for it to go high
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 9600
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx_in,
   output logic [UART_DATA_BITS-1:0] rx_data,
   output logic                      rx_valid,
   output logic                      rx_frame_err,
`ifdef UART_RX_PARITY_EN
   output logic                      rx_parity_err,
`endif
   output logic                      rx_busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W        = uart_clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

   logic                      w_rx_s;

   uart_state_t               r_state;
   uart_state_t               w_state_nxt;
   logic [CNT_W-1:0]          r_cnt;
   logic [CNT_W-1:0]          w_cnt_nxt;
   logic [2:0]                r_bit_idx;
   logic [2:0]                w_bit_idx_nxt;
   logic [UART_DATA_BITS-1:0] r_shift;
   logic [UART_DATA_BITS-1:0] w_shift_nxt;
   logic [UART_DATA_BITS-1:0] r_data;
   logic [UART_DATA_BITS-1:0] w_data_nxt;
   logic                      r_valid;
   logic                      w_valid_nxt;
   logic                      r_ferr;
   logic                      w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
   logic                      r_par_bad;
   logic                      w_par_bad_nxt;
   logic                      r_perr;
   logic                      w_perr_nxt;
`endif

   uart_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_in),
      .q   (w_rx_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bad <= 1'b0;
         r_perr    <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
         r_data    <= w_data_nxt;
         r_valid   <= w_valid_nxt;
         r_ferr    <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
         r_par_bad <= w_par_bad_nxt;
         r_perr    <= w_perr_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt + CNT_W'(1);
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_data_nxt    = r_data;
      w_valid_nxt   = 1'b0;
      w_ferr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_bad_nxt = r_par_bad;
      w_perr_nxt    = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            if (!w_rx_s) begin
               w_state_nxt = START;
            end
         end
         START: begin
            if (r_cnt == HALF_CNT) begin
               w_cnt_nxt     = '0;
               w_bit_idx_nxt = '0;
               w_state_nxt   = w_rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (r_cnt == LAST_CNT) begin
               w_cnt_nxt     = '0;
               w_shift_nxt   = {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
               w_bit_idx_nxt = r_bit_idx + 3'd1;
               if (r_bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = PARITY;
`else
                  w_state_nxt = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (r_cnt == LAST_CNT) begin
               w_cnt_nxt     = '0;
               w_par_bad_nxt = (^r_shift) ^ w_rx_s;
               w_state_nxt   = STOP;
            end
         end
`endif
         STOP: begin
            // IDLE is re-entered at mid-stop so a following start edge is not missed
            if (r_cnt == LAST_CNT) begin
               w_cnt_nxt = '0;
               if (w_rx_s) begin
                  w_data_nxt  = r_shift;
                  w_valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                  w_perr_nxt  = r_par_bad;
`endif
                  w_state_nxt = IDLE;
               end else begin
                  w_ferr_nxt  = 1'b1;
                  w_state_nxt = BREAK;
               end
            end
         end
         BREAK: begin
            w_cnt_nxt = '0;
            if (w_rx_s) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign rx_data      = r_data;
   assign rx_valid     = r_valid;
   assign rx_frame_err = r_ferr;
   assign rx_busy      = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
   assign rx_parity_err = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed and random frames against a
// queue-based reference of expected bytes, strobes and timing.
module tb_uart_rx;

   localparam int CLK_FREQ  = 160000;
   localparam int BAUD_RATE = 10000;
   localparam int CPB       = CLK_FREQ / BAUD_RATE;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int LATENCY = CPB / 2 + (FRAME_BITS - 1) * CPB + 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_in = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_busy;
`ifdef UART_RX_PARITY_EN
   logic       rx_parity_err;
`endif

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_in        (rx_in),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_frame_err (rx_frame_err),
`ifdef UART_RX_PARITY_EN
      .rx_parity_err(rx_parity_err),
`endif
      .rx_busy      (rx_busy)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // observations, gathered 1 time unit after each rising edge
   int         cyc = 0;
   int         ferr_cnt = 0;
   int         both_cnt = 0;
   int         busy_run = 0;
   int         max_busy = 0;
   logic [7:0] got_q[$];
   logic       gotp_q[$];
   int         vcyc_q[$];

   // reference model
   logic [7:0] exp_q[$];
   logic       expp_q[$];
   logic [7:0] last_good = 8'h00;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (rx_valid) begin
         got_q.push_back(rx_data);
         vcyc_q.push_back(cyc);
`ifdef UART_RX_PARITY_EN
         gotp_q.push_back(rx_parity_err);
`else
         gotp_q.push_back(1'b0);
`endif
      end
      if (rx_frame_err) ferr_cnt++;
      if (rx_valid && rx_frame_err) both_cnt++;
      if (rx_busy) begin
         busy_run++;
         if (busy_run > max_busy) max_busy = busy_run;
      end else begin
         busy_run = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      got_q.delete();
      gotp_q.delete();
      vcyc_q.delete();
      exp_q.delete();
      expp_q.delete();
      ferr_cnt = 0;
      both_cnt = 0;
      max_busy = 0;
   endtask

   // A good frame is expected to deliver its byte; bad_par flags a wrong parity bit.
   task automatic expect_frame(input logic [7:0] d, input logic bad_par);
      exp_q.push_back(d);
`ifdef UART_RX_PARITY_EN
      expp_q.push_back(bad_par);
`else
      expp_q.push_back(1'b0 & bad_par);
`endif
      last_good = d;
   endtask

   // Drives one frame. skew moves each inner bit edge by up to +/-skew clk;
   // alt instead moves the edges alternately by -3/+3 clk.
   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic bad_par,
                             input int skew, input bit alt, output int t_start);
      logic [11:0] bits;
      int          n;
      int          off_prev;
      int          off_next;
      int          dur;
      bits    = '1;
      bits[0] = 1'b0;
      for (int j = 0; j < 8; j++) bits[1+j] = d[j];
`ifdef UART_RX_PARITY_EN
      bits[9]  = (^d) ^ bad_par;
      bits[10] = stop_b;
      n = 11;
`else
      bits[9]  = stop_b;
      bits[11] = bad_par;
      n = 10;
`endif
      t_start  = cyc;
      off_prev = 0;
      for (int i = 0; i < n; i++) begin
         if (i == n - 1)  off_next = 0;
         else if (alt)    off_next = (i % 2 == 0) ? -3 : 3;
         else if (skew > 0) off_next = int'($urandom_range(0, 2 * skew)) - skew;
         else             off_next = 0;
         dur   = CPB + off_next - off_prev;
         rx_in = bits[i];
         repeat (dur) @(negedge clk);
         off_prev = off_next;
      end
   endtask

   task automatic check_frames(input string tag);
      chk($sformatf("%s_count", tag), got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         chk($sformatf("%s_data%0d", tag, i), {24'h0, got_q[i]}, {24'h0, exp_q[i]});
`ifdef UART_RX_PARITY_EN
         chk($sformatf("%s_perr%0d", tag, i), {31'h0, gotp_q[i]}, {31'h0, expp_q[i]});
`endif
      end
      chk($sformatf("%s_both", tag), both_cnt, 0);
   endtask

   initial begin
      int         t0;
      int         t1;
      int         tr;
      logic [7:0] d;
      logic       bad;
      logic [7:0] prev;

      // reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_data", {24'h0, rx_data}, 32'h0);
      chk("rst_valid", {31'h0, rx_valid}, 32'h0);
      chk("rst_ferr", {31'h0, rx_frame_err}, 32'h0);
      chk("rst_busy", {31'h0, rx_busy}, 32'h0);
`ifdef UART_RX_PARITY_EN
      chk("rst_perr", {31'h0, rx_parity_err}, 32'h0);
`endif
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // back-to-back frames, then random bytes with random idle gaps
      clear_obs();
      send_frame(8'h55, 1'b1, 1'b0, 0, 1'b0, t0);
      expect_frame(8'h55, 1'b0);
      send_frame(8'hA3, 1'b1, 1'b0, 0, 1'b0, t1);
      expect_frame(8'hA3, 1'b0);
      repeat (24) @(negedge clk);
      if (vcyc_q.size() > 1) begin
         chk("lat_first", vcyc_q[0] - t0, LATENCY);
         chk("lat_second", vcyc_q[1] - t1, LATENCY);
      end
      for (int k = 0; k < 10; k++) begin
         d = 8'($urandom);
`ifdef UART_RX_PARITY_EN
         bad = 1'($urandom_range(0, 1));
`else
         bad = 1'b0;
`endif
         send_frame(d, 1'b1, bad, 0, 1'b0, tr);
         expect_frame(d, bad);
         repeat ($urandom_range(0, 8)) @(negedge clk);
      end
      repeat (24) @(negedge clk);
      check_frames("b2b");
      chk("b2b_ferr", ferr_cnt, 0);

      // short glitch on an idle line
      clear_obs();
      rx_in = 1'b0;
      repeat (5) @(negedge clk);
      rx_in = 1'b1;
      repeat (30) @(negedge clk);
      chk("glitch_valid", got_q.size(), 0);
      chk("glitch_ferr", ferr_cnt, 0);
      chk("glitch_busy_len", max_busy, CPB / 2);

      // bad stop bit followed by a held-low line
      clear_obs();
      prev = last_good;
      send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0, tr);
      repeat (40) @(negedge clk);
      chk("brk_ferr", ferr_cnt, 1);
      chk("brk_valid", got_q.size(), 0);
      chk("brk_data_held", {24'h0, rx_data}, {24'h0, prev});
      rx_in = 1'b1;
      repeat (CPB) @(negedge clk);
      send_frame(8'h81, 1'b1, 1'b0, 0, 1'b0, tr);
      expect_frame(8'h81, 1'b0);
      repeat (24) @(negedge clk);
      check_frames("brk");
      chk("brk_ferr_total", ferr_cnt, 1);

      // async reset in the middle of bit 4; bad_par keeps the line high for
      // the rest of the aborted frame so no false start bit follows
      clear_obs();
      fork
         send_frame(8'hFF, 1'b1, 1'b1, 0, 1'b0, tr);
         begin
            repeat (CPB * 5 + CPB / 2) @(negedge clk);
            #3;
            rst = 1'b1;
            #1;
            chk("arst_data", {24'h0, rx_data}, 32'h0);
            chk("arst_valid", {31'h0, rx_valid}, 32'h0);
            chk("arst_ferr", {31'h0, rx_frame_err}, 32'h0);
            chk("arst_busy", {31'h0, rx_busy}, 32'h0);
            @(negedge clk);
            rst = 1'b0;
         end
      join
      last_good = 8'h00;
      repeat (24) @(negedge clk);
      chk("arst_no_frame", got_q.size(), 0);
      send_frame(8'h12, 1'b1, 1'b0, 0, 1'b0, tr);
      expect_frame(8'h12, 1'b0);
      repeat (24) @(negedge clk);
      check_frames("arst");

      // skewed bit edges
      clear_obs();
      send_frame(8'h55, 1'b1, 1'b0, 0, 1'b1, tr);
      expect_frame(8'h55, 1'b0);
      for (int k = 0; k < 6; k++) begin
         d = 8'($urandom);
         send_frame(d, 1'b1, 1'b0, 3, 1'b0, tr);
         expect_frame(d, 1'b0);
         repeat ($urandom_range(0, 6)) @(negedge clk);
      end
      repeat (24) @(negedge clk);
      check_frames("skew");
      chk("skew_ferr", ferr_cnt, 0);

`ifdef UART_RX_PARITY_EN
      // parity good then parity bad on the same byte
      clear_obs();
      send_frame(8'h07, 1'b1, 1'b0, 0, 1'b0, tr);
      expect_frame(8'h07, 1'b0);
      send_frame(8'h07, 1'b1, 1'b1, 0, 1'b0, tr);
      expect_frame(8'h07, 1'b1);
      repeat (24) @(negedge clk);
      check_frames("par");
      chk("par_ferr", ferr_cnt, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
